acquisition_ctrl: RTL and testbench

//  Consumes the filtered sample stream (data + rdy strobe) of the ADC block and runs one oscilloscope acquisition.

---
 rtl/acquisition_ctrl_pkg.sv | 23 ++
 rtl/acquisition_ctrl_trigger_detector.sv | 37 +++
 rtl/acquisition_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_acquisition_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/acquisition_ctrl_pkg.sv
// Shared register map, ctrl bit positions and FSM encoding
// for the oscilloscope acquisition controller.
package acquisition_ctrl_pkg;

   localparam int ADDR_ACQ_CTRL     = 3;
   localparam int ADDR_TRIG_LEVEL   = 4;
   localparam int ADDR_PRETRIG      = 5;
   localparam int ADDR_NUM_SAMPLES  = 6;
   localparam int ADDR_AUTO_TIMEOUT = 7;

   localparam int CTRL_START = 0;
   localparam int CTRL_ABORT = 1;
   localparam int CTRL_EDGE  = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_WAIT,
      S_POST,
      S_DONE
   } acq_state_t;

endpackage

// File: rtl/acquisition_ctrl_trigger_detector.sv
// Edge trigger: previous-sample register, valid flag and
// unsigned level compare for rising or falling edges.
module acquisition_ctrl_trigger_detector #(
   parameter int BITS_DATA = 8
) (
   input  logic                 clk_i,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 smp,
   input  logic [BITS_DATA-1:0] data,
   input  logic [BITS_DATA-1:0] level,
   input  logic                 edge_sel,
   output logic                 trig
);

   logic [BITS_DATA-1:0] prev;
   logic                 valid;

   // clr beats smp so a sample on the entry cycle is never a prev
   always_ff @(posedge clk_i) begin
      if (rst || clr) begin
         prev  <= '0;
         valid <= 1'b0;
      end else if (smp) begin
         prev  <= data;
         valid <= 1'b1;
      end
   end

   always_comb begin
      if (edge_sel)
         trig = valid && (prev > level) && (data <= level);
      else
         trig = valid && (prev < level) && (data >= level);
   end

endmodule

// File: rtl/acquisition_ctrl.sv
// Acquisition controller: circular sample capture with edge trigger.
// Optional auto-trigger timeout enabled by ACQ_AUTO_TRIGGER_EN.
module acquisition_ctrl
   import acquisition_ctrl_pkg::*;
#(
   parameter int BITS_DATA           = 8,
   parameter int RAM_ADDR_WIDTH      = 10,
   parameter int REG_DATA_WIDTH      = 16,
   parameter int REG_ADDR_WIDTH      = 8,
   parameter int DEFAULT_TRIG_LEVEL  = 128,
   parameter int DEFAULT_PRETRIG     = 0,
   parameter int DEFAULT_NUM_SAMPLES = 2**RAM_ADDR_WIDTH
) (
   input  logic                      clk_i,
   input  logic                      rst,
   input  logic [BITS_DATA-1:0]      si_data_i,
   input  logic                      si_rdy_i,
   input  logic [REG_DATA_WIDTH-1:0] reg_si_data,
   input  logic [REG_ADDR_WIDTH-1:0] reg_si_addr,
   input  logic                      reg_si_rdy,
   output logic                      ram_we_o,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
   output logic [BITS_DATA-1:0]      ram_data_o,
   output logic [RAM_ADDR_WIDTH-1:0] trig_addr_o,
   output logic                      acq_done_o,
   output logic                      busy_o
);

   localparam int DEPTH = 2**RAM_ADDR_WIDTH;
   localparam int CW    = RAM_ADDR_WIDTH + 1;

   acq_state_t state, state_n;

   logic [BITS_DATA-1:0]      trig_level;
   logic [REG_DATA_WIDTH-1:0] pretrig;
   logic [REG_DATA_WIDTH-1:0] num_samples;
   logic                      edge_sel;

   logic [RAM_ADDR_WIDTH-1:0] ptr;
   logic [CW-1:0]             cnt, cnt_inc;
   logic [CW-1:0]             p_len, post_len;
   logic [CW-1:0]             n_eff, p_eff;

   logic ctrl_wr, start_w, abort_w;
   logic active, accept;
   logic det_clr, det_trig, auto_hit, trig_hit;

   function automatic logic hit(input logic [REG_ADDR_WIDTH-1:0] a,
                                input int                        r);
      return reg_si_rdy && (a == REG_ADDR_WIDTH'(r));
   endfunction

   assign ctrl_wr = hit(reg_si_addr, ADDR_ACQ_CTRL);
   assign abort_w = ctrl_wr && reg_si_data[CTRL_ABORT];
   assign start_w = ctrl_wr && reg_si_data[CTRL_START]
                    && !reg_si_data[CTRL_ABORT];

   assign active = (state == S_PRE) || (state == S_WAIT)
                   || (state == S_POST);
   assign accept = si_rdy_i && active && !start_w && !abort_w;

   assign cnt_inc  = cnt + CW'(1);
   assign trig_hit = (state == S_WAIT) && (det_trig || auto_hit);

   assign acq_done_o = (state == S_DONE);
   assign busy_o     = active;

   always_comb begin
      n_eff = num_samples[CW-1:0];
      if (num_samples == '0
          || num_samples > REG_DATA_WIDTH'(DEPTH))
         n_eff = CW'(DEPTH);
      p_eff = pretrig[CW-1:0];
      if (pretrig >= REG_DATA_WIDTH'(n_eff))
         p_eff = n_eff - CW'(1);
   end

   always_comb begin
      state_n = state;
      det_clr = 1'b0;
      unique case (state)
         S_PRE: begin
            if (accept && cnt_inc == p_len) begin
               state_n = S_WAIT;
               det_clr = 1'b1;
            end
         end
         S_WAIT: begin
            if (accept && trig_hit)
               state_n = (post_len == '0) ? S_DONE : S_POST;
         end
         S_POST: begin
            if (accept && cnt_inc == post_len)
               state_n = S_DONE;
         end
         default: ;
      endcase
      if (abort_w) begin
         state_n = S_IDLE;
      end else if (start_w) begin
         state_n = (p_eff == '0) ? S_WAIT : S_PRE;
         det_clr = 1'b1;
      end
   end

`ifdef ACQ_AUTO_TRIGGER_EN
   logic [REG_DATA_WIDTH-1:0] timeout;
   logic [REG_DATA_WIDTH-1:0] wait_cnt, wait_inc;

   assign wait_inc = wait_cnt + REG_DATA_WIDTH'(1);
   assign auto_hit = (timeout != '0) && (wait_inc == timeout);

   always_ff @(posedge clk_i) begin
      if (rst || start_w || state_n != state)
         wait_cnt <= '0;
      else if (accept && state == S_WAIT)
         wait_cnt <= wait_inc;
   end
`else
   assign auto_hit = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst) begin
         trig_level  <= BITS_DATA'(DEFAULT_TRIG_LEVEL);
         pretrig     <= REG_DATA_WIDTH'(DEFAULT_PRETRIG);
         num_samples <= REG_DATA_WIDTH'(DEFAULT_NUM_SAMPLES);
         edge_sel    <= 1'b0;
`ifdef ACQ_AUTO_TRIGGER_EN
         timeout     <= '0;
`endif
      end else begin
         unique case (1'b1)
            ctrl_wr:
               edge_sel <= reg_si_data[CTRL_EDGE];
            hit(reg_si_addr, ADDR_TRIG_LEVEL):
               trig_level <= reg_si_data[BITS_DATA-1:0];
            hit(reg_si_addr, ADDR_PRETRIG):
               pretrig <= reg_si_data;
            hit(reg_si_addr, ADDR_NUM_SAMPLES):
               num_samples <= reg_si_data;
`ifdef ACQ_AUTO_TRIGGER_EN
            hit(reg_si_addr, ADDR_AUTO_TIMEOUT):
               timeout <= reg_si_data;
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         state       <= S_IDLE;
         ptr         <= '0;
         cnt         <= '0;
         p_len       <= '0;
         post_len    <= '0;
         ram_we_o    <= 1'b0;
         ram_addr_o  <= '0;
         ram_data_o  <= '0;
         trig_addr_o <= '0;
      end else begin
         state    <= state_n;
         ram_we_o <= accept;
         if (start_w || state_n != state)
            cnt <= '0;
         else if (accept)
            cnt <= cnt_inc;
         if (start_w) begin
            ptr         <= '0;
            p_len       <= p_eff;
            post_len    <= n_eff - p_eff - CW'(1);
            trig_addr_o <= '0;
         end else if (accept) begin
            ram_addr_o <= ptr;
            ram_data_o <= si_data_i;
            ptr        <= ptr + 1'b1;
            if (trig_hit)
               trig_addr_o <= ptr;
         end
      end
   end

   acquisition_ctrl_trigger_detector #(
      .BITS_DATA(BITS_DATA)
   ) u_trig (
      .clk_i    (clk_i),
      .rst      (rst),
      .clr      (det_clr),
      .smp      (accept),
      .data     (si_data_i),
      .level    (trig_level),
      .edge_sel (edge_sel),
      .trig     (det_trig)
   );

endmodule

// File: tb/tb_acquisition_ctrl.sv
// Directed bench for acquisition_ctrl (RAM_ADDR_WIDTH=4).
// Covers ACQ_AUTO_TRIGGER_EN in either build.
module tb_acquisition_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] si_data;
   logic       si_rdy;
   logic [15:0] reg_si_data;
   logic [7:0] reg_si_addr;
   logic       reg_si_rdy;
   logic       ram_we;
   logic [3:0] ram_addr;
   logic [7:0] ram_data;
   logic [3:0] trig_addr;
   logic       acq_done;
   logic       busy;

   int total = 0;
   int pass_cnt = 0;
   int we_cnt = 0;

   always #5 clk = ~clk;

   acquisition_ctrl #(
      .BITS_DATA      (8),
      .RAM_ADDR_WIDTH (4),
      .REG_DATA_WIDTH (16),
      .REG_ADDR_WIDTH (8)
   ) dut (
      .clk_i       (clk),
      .rst         (rst),
      .si_data_i   (si_data),
      .si_rdy_i    (si_rdy),
      .reg_si_data (reg_si_data),
      .reg_si_addr (reg_si_addr),
      .reg_si_rdy  (reg_si_rdy),
      .ram_we_o    (ram_we),
      .ram_addr_o  (ram_addr),
      .ram_data_o  (ram_data),
      .trig_addr_o (trig_addr),
      .acq_done_o  (acq_done),
      .busy_o      (busy)
   );

   always @(negedge clk)
      if (ram_we === 1'b1) we_cnt++;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: got %0h expected %0h",
                  tag, obs, exp);
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      @(negedge clk);
      reg_si_addr = a;
      reg_si_data = d;
      reg_si_rdy  = 1'b1;
      @(negedge clk);
      reg_si_rdy  = 1'b0;
   endtask

   task automatic smp(input logic [7:0] d);
      @(negedge clk);
      si_data = d;
      si_rdy  = 1'b1;
      @(negedge clk);
      si_rdy  = 1'b0;
   endtask

   task automatic setup(input int lvl, input int p,
                        input int n, input int ctrl);
      wr(8'd4, 16'(lvl));
      wr(8'd5, 16'(p));
      wr(8'd6, 16'(n));
      wr(8'd3, 16'(ctrl));
   endtask

   initial begin
      rst = 1'b1;
      si_data = '0;
      si_rdy = 1'b0;
      reg_si_data = '0;
      reg_si_addr = '0;
      reg_si_rdy = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      chk("rst_we", ram_we, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_data", ram_data, 0);
      chk("rst_trig", trig_addr, 0);
      chk("rst_done", acq_done, 0);
      chk("rst_busy", busy, 0);

      for (int i = 0; i < 20; i++) smp(8'(i * 7 + 3));
      chk("idle_we", we_cnt, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", acq_done, 0);

      // rising at 105, N=16, P=4: 110 at index 11 triggers
      setup(105, 4, 16, 1);
      chk("ramp_busy", busy, 1);
      for (int i = 0; i < 12; i++) begin
         smp(8'(i * 10));
         chk("ramp_addr", ram_addr, 32'(i));
         chk("ramp_data", ram_data, 32'(i * 10));
      end
      for (int i = 12; i < 23; i++) begin
         smp(8'(i * 10));
         chk("ramp_we", ram_we, 1);
         chk("ramp_paddr", ram_addr, 32'(i % 16));
         chk("ramp_done", acq_done, 32'(i == 22));
      end
      chk("ramp_taddr", trig_addr, 11);
      chk("ramp_nbusy", busy, 0);
      smp(8'd1);
      chk("done_drop", ram_we, 0);

      // falling at 50, N=8, P=0
      setup(50, 0, 8, 5);
      smp(8'd60);
      chk("fall_a0", ram_addr, 0);
      smp(8'd40);
      chk("fall_a1", ram_addr, 1);
      for (int i = 0; i < 7; i++) begin
         smp(8'd30);
         chk("fall_done", acq_done, 32'(i == 6));
      end
      chk("fall_taddr", trig_addr, 1);
      chk("fall_last", ram_addr, 8);

      // wrap: P=2, N=8, no trigger for 40 samples
      setup(200, 2, 8, 1);
      for (int k = 0; k < 40; k++) begin
         smp(8'd10);
         chk("wrap_addr", ram_addr, 32'(k % 16));
      end
      chk("wrap_busy", busy, 1);
      chk("wrap_ndone", acq_done, 0);
      smp(8'd250);
      chk("wrap_tpt", ram_addr, 8);
      for (int i = 0; i < 5; i++) begin
         smp(8'd250);
         chk("wrap_done", acq_done, 32'(i == 4));
      end
      chk("wrap_taddr", trig_addr, 8);

      // clamp: N=4, P=9 -> P=3, done on the trigger write
      setup(100, 9, 4, 1);
      for (int i = 0; i < 4; i++) smp(8'd5);
      chk("clamp_ndone", acq_done, 0);
      smp(8'd150);
      chk("clamp_addr", ram_addr, 4);
      chk("clamp_done", acq_done, 1);
      chk("clamp_taddr", trig_addr, 4);

      // abort mid-POST, then start+abort together
      setup(100, 0, 16, 1);
      smp(8'd10);
      smp(8'd200);
      repeat (3) smp(8'd210);
      chk("post_busy", busy, 1);
      wr(8'd3, 16'd2);
      chk("abort_busy", busy, 0);
      chk("abort_done", acq_done, 0);
      smp(8'd7);
      chk("abort_drop", ram_we, 0);
      wr(8'd3, 16'd1);
      chk("restart_busy", busy, 1);
      wr(8'd3, 16'd3);
      chk("sa_busy", busy, 0);
      chk("sa_done", acq_done, 0);

`ifdef ACQ_AUTO_TRIGGER_EN
      wr(8'd7, 16'd5);
      setup(100, 0, 16, 1);
      for (int k = 0; k < 20; k++) begin
         smp(8'd50);
         chk("auto_done", acq_done, 32'(k == 19));
      end
      chk("auto_taddr", trig_addr, 4);
`else
      wr(8'd7, 16'd5);
      setup(100, 0, 16, 1);
      for (int k = 0; k < 1000; k++) smp(8'd50);
      chk("noauto_busy", busy, 1);
      chk("noauto_done", acq_done, 0);
      chk("noauto_addr", ram_addr, 7);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
